// File: rtl/tt_mizidd_alu_pkg.sv
// tt_mizidd_alu_pkg
// Definitions shared by the accumulator ALU and its program sequencer:
// opcode encodings, instruction layout and the sequencer state encoding.
// No ports; import with "import tt_mizidd_alu_pkg::*;".
package tt_mizidd_alu_pkg;

    localparam int OPC_W   = 3;
    localparam int ALU_W   = 7;
    localparam int INSTR_W = OPC_W + ALU_W;   // {opcode, operand}

    localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OPC_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;  // sequencer-local, never issued

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    // Opcodes 100..110 are reserved; they go out to the ALU as NOP.
    function automatic logic is_reserved(input logic [OPC_W-1:0] opc);
        return opc[2] && (opc != OP_HALT);
    endfunction

endpackage

// File: rtl/tt_mizidd_alu_prog_mem.sv
// tt_mizidd_alu_prog_mem
// Program storage: DEPTH x IW register file, one synchronous write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (combinational)
module tt_mizidd_alu_prog_mem #(
    parameter int DEPTH = 8,
    parameter int IW    = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [IW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [IW-1:0]            rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tt_mizidd_alu_sequencer.sv
// tt_mizidd_alu_sequencer
// Stores a short instruction list and replays it into the accumulator ALU,
// one instruction per enabled cycle, then captures accumulator and carry.
//
// state  | meaning
// IDLE   | accepting program edits and start
// RUN    | issuing stored instructions
// DRAIN  | NOP cycle so the ALU registers the last instruction
// DONE   | result captured, done pulse visible
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ena                   global enable (low: hold everything, opcode -> NOP)
//   prog_clr/prog_we      program clear / append (IDLE only)
//   prog_data             {opcode, operand} to append
//   start                 begin execution (IDLE, non-empty program)
//   alu_opcode/operand    registered instruction to the ALU
//   alu_accu/alu_carry    ALU state, captured at the end of a run
//   busy, done            run in progress / one-cycle completion pulse
//   result/result_carry   captured ALU state
//   prog_count            number of stored entries
module tt_mizidd_alu_sequencer
    import tt_mizidd_alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ALU_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   prog_clr,
    input  logic                   prog_we,
    input  logic [OPC_W+W-1:0]     prog_data,
    input  logic                   start,
    output logic [OPC_W-1:0]       alu_opcode,
    output logic [W-1:0]           alu_operand,
    input  logic [W-1:0]           alu_accu,
    input  logic                   alu_carry,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           result,
    output logic                   result_carry,
    output logic [$clog2(DEPTH):0] prog_count
);

    localparam int IW = OPC_W + W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [W-1:0]     opr_q, opr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     res_q, res_d;
    logic             resc_q, resc_d;

    logic             mem_we;
    logic [AW-1:0]    mem_raddr;
    logic [IW-1:0]    mem_rdata;
    logic [OPC_W-1:0] rd_opc;
    logic [W-1:0]     rd_opr;
    logic [OPC_W-1:0] issue_opc;
    logic [W-1:0]     issue_opr;

    tt_mizidd_alu_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we && ena),
        .waddr (count_q[AW-1:0]),
        .wdata (prog_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // In IDLE the read port looks at entry 0 so start can issue it directly.
    assign mem_raddr = (state_q == S_IDLE) ? '0 : rd_ptr_q[AW-1:0];
    assign rd_opc    = mem_rdata[IW-1:W];
    assign rd_opr    = mem_rdata[W-1:0];
    assign issue_opc = is_reserved(rd_opc) ? OP_NOP : rd_opc;
    assign issue_opr = is_reserved(rd_opc) ? '0 : rd_opr;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        opc_d    = opc_q;
        opr_d    = opr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;
        resc_d   = resc_q;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (count_q != '0)) begin
                    busy_d   = 1'b1;
                    rd_ptr_d = CW'(1);
                    if (rd_opc == OP_HALT) begin
                        opc_d   = OP_NOP;
                        opr_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        opc_d   = issue_opc;
                        opr_d   = issue_opr;
                        state_d = S_RUN;
                    end
                end else if (prog_clr) begin
                    count_d = '0;
                end else if (prog_we && (count_q < FULL)) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            S_RUN: begin
                if ((rd_ptr_q < count_q) && (rd_opc != OP_HALT)) begin
                    opc_d    = issue_opc;
                    opr_d    = issue_opr;
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end else begin
                    opc_d   = OP_NOP;
                    opr_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                res_d   = alu_accu;
                resc_d  = alu_carry;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            count_q  <= '0;
            opc_q    <= OP_NOP;
            opr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            resc_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            opc_q    <= opc_d;
            opr_q    <= opr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
            resc_q   <= resc_d;
        end
    end

    // The ALU must see NOP for every cycle the sequencer is frozen.
    assign alu_opcode   = ena ? opc_q : OP_NOP;
    assign alu_operand  = opr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = res_q;
    assign result_carry = resc_q;
    assign prog_count   = count_q;

endmodule

// File: tb/tb_tt_mizidd_alu_sequencer.sv
// Testbench for tt_mizidd_alu_sequencer with a behavioural ALU in the loop.
module tb_tt_mizidd_alu_sequencer;
    import tt_mizidd_alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 7;
    localparam int IW    = 3 + W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b1;
    logic          prog_clr = 1'b0;
    logic          prog_we = 1'b0;
    logic [IW-1:0] prog_data = '0;
    logic          start = 1'b0;
    logic [2:0]    alu_opcode;
    logic [W-1:0]  alu_operand;
    logic [W-1:0]  alu_accu;
    logic          alu_carry;
    logic          busy, done, result_carry;
    logic [W-1:0]  result;
    logic [CW-1:0] prog_count;

    always #5 clk = ~clk;

    tt_mizidd_alu_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prog_clr(prog_clr),
        .prog_we(prog_we), .prog_data(prog_data), .start(start),
        .alu_opcode(alu_opcode), .alu_operand(alu_operand),
        .alu_accu(alu_accu), .alu_carry(alu_carry), .busy(busy), .done(done),
        .result(result), .result_carry(result_carry), .prog_count(prog_count)
    );

    // ALU stand-in: registers one instruction per clock; carry is the ADD
    // carry-out or the SUB borrow, LOAD clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_accu  <= '0;
            alu_carry <= 1'b0;
        end else begin
            case (alu_opcode)
                OP_LOAD: begin alu_accu <= alu_operand; alu_carry <= 1'b0; end
                OP_ADD:  {alu_carry, alu_accu} <= {1'b0, alu_accu} + {1'b0, alu_operand};
                OP_SUB:  begin alu_accu <= alu_accu - alu_operand; alu_carry <= (alu_accu < alu_operand); end
                default: ;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int res;
        int carry;
        int cycles;
    } run_exp_t;

    run_exp_t      exp_q[$];
    logic [IW-1:0] iss_q[$];

    // Reference state: program contents, entry count, ALU accumulator.
    logic [IW-1:0] prog_m [DEPTH];
    int            cnt_m = 0;
    int            ref_acc = 0;
    int            ref_c = 0;

    // Monitor: every enabled busy cycle shows one issued instruction; done
    // carries the captured result and closes the busy-cycle count.
    int busy_cnt = 0;
    bit done_prev = 0;
    always @(negedge clk) begin : monitor
        run_exp_t      e;
        logic [IW-1:0] ie;
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 0;
        end else begin
            if (done_prev && ena) begin
                chk("done_pulse_width", done, 0);
                done_prev = 0;
            end
            if (busy) busy_cnt++;
            if (!ena) chk("nop_when_disabled", alu_opcode, 0);
            if (busy && ena) begin
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected: got opcode %0d operand %0d expected nothing", alu_opcode, alu_operand);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue_opcode", alu_opcode, ie[IW-1:W]);
                    chk("issue_operand", alu_operand, ie[W-1:0]);
                end
            end
            if (done && ena) begin
                done_prev = 1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done=1 expected no done");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("result_carry", result_carry, e.carry);
                    chk("busy_cycles", busy_cnt, e.cycles);
                    chk("iss_queue_drained", iss_q.size(), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] opc, input int opr);
        prog_we   = 1'b1;
        prog_data = {opc, W'(opr)};
        tick();
        prog_we   = 1'b0;
        if (cnt_m < DEPTH) begin
            prog_m[cnt_m] = {opc, W'(opr)};
            cnt_m++;
        end
    endtask

    task automatic clr();
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
        cnt_m = 0;
    endtask

    // Walk the stored program the way the sequencer is meant to, pushing the
    // instruction stream the ALU should see and the final accumulator.
    task automatic expect_run(input int gap);
        int a = ref_acc;
        int c = ref_c;
        int n = 0;
        for (int i = 0; i < cnt_m; i++) begin
            logic [2:0] op;
            int opr;
            op  = prog_m[i][IW-1:W];
            opr = int'(prog_m[i][W-1:0]);
            if (op == OP_HALT) break;
            if (op >= 3'd4) begin
                iss_q.push_back('0);
            end else begin
                iss_q.push_back(prog_m[i]);
                if (op == OP_LOAD) begin
                    a = opr; c = 0;
                end else if (op == OP_ADD) begin
                    c = (a + opr > 127) ? 1 : 0;
                    a = (a + opr) % 128;
                end else if (op == OP_SUB) begin
                    c = (a < opr) ? 1 : 0;
                    a = (a - opr + 128) % 128;
                end
            end
            n++;
        end
        iss_q.push_back('0);
        exp_q.push_back('{a, c, n + 1 + gap});
        ref_acc = a;
        ref_c   = c;
    endtask

    task automatic run_prog(input int gap, input bit noise);
        int t;
        expect_run(gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (gap > 0) begin
            ena = 1'b0;
            repeat (gap) tick();
            ena = 1'b1;
        end
        if (noise) begin
            prog_we   = 1'b1;
            prog_clr  = 1'($urandom);
            prog_data = IW'($urandom);
        end
        for (t = 0; t < 64 && !done; t++) tick();
        prog_we  = 1'b0;
        prog_clr = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", t);
            iss_q.delete();
            exp_q.delete();
        end
        tick();
        tick();
        chk("prog_count_after_run", prog_count, cnt_m);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_operand", alu_operand, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", result_carry, 0);
        chk("rst_count", prog_count, 0);
        iss_q.delete();
        exp_q.delete();
        cnt_m = 0; ref_acc = 0; ref_c = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return OP_NOP;
            1, 2, 9: return OP_LOAD;
            3, 4:    return OP_ADD;
            5, 6:    return OP_SUB;
            7:       return OP_HALT;
            default: return 3'(3'd4 + $urandom_range(0, 2));
        endcase
    endfunction

    initial begin
        tick();
        do_reset();

        // LOAD 5, ADD 3, SUB 2
        clr();
        wr(OP_LOAD, 5); wr(OP_ADD, 3); wr(OP_SUB, 2);
        chk("count_3", prog_count, 3);
        run_prog(0, 0);
        chk("prog1_result", result, 6);
        run_prog(3, 0);
        chk("gap_result", result, 6);
        run_prog(0, 1);
        chk("rerun_result", result, 6);

        // carry out of the top bit
        do_reset();
        wr(OP_LOAD, 127); wr(OP_ADD, 1);
        run_prog(0, 0);
        chk("wrap_result", result, 0);
        chk("wrap_carry", result_carry, 1);

        // HALT mid-program stops issue
        clr();
        wr(OP_LOAD, 9); wr(OP_HALT, 0); wr(OP_ADD, 1);
        run_prog(0, 0);
        chk("halt_result", result, 9);

        // HALT at entry 0: nothing issued, accumulator unchanged
        clr();
        wr(OP_HALT, 0); wr(OP_LOAD, 4);
        run_prog(2, 0);
        chk("halt0_result", result, 9);

        // reserved opcode goes out as NOP/0
        clr();
        wr(OP_LOAD, 1); wr(3'b101, 55); wr(OP_ADD, 2);
        run_prog(0, 0);
        chk("reserved_result", result, 3);

        // overflow and clear priority
        clr();
        for (int i = 0; i < 9; i++) wr(OP_ADD, i);
        chk("count_full", prog_count, 8);
        prog_clr = 1'b1; prog_we = 1'b1;
        tick();
        prog_clr = 1'b0; prog_we = 1'b0;
        cnt_m = 0;
        chk("clr_over_we", prog_count, 0);

        // start on empty program is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_empty_busy", busy, 0);
        tick();
        chk("start_empty_busy2", busy, 0);

        // asynchronous reset mid-run: no done afterwards
        wr(OP_LOAD, 20); wr(OP_ADD, 1); wr(OP_ADD, 2); wr(OP_ADD, 3);
        expect_run(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midrun_busy", busy, 1);
        do_reset();
        repeat (10) tick();
        chk("post_reset_busy", busy, 0);

        // randomized programs
        for (int r = 0; r < 30; r++) begin
            int nw;
            if ($urandom_range(0, 3) != 0 || cnt_m == 0) begin
                clr();
                nw = $urandom_range(1, 9);
                for (int k = 0; k < nw; k++) wr(rand_op(), int'($urandom_range(0, 127)));
                chk("rand_count", prog_count, cnt_m);
            end
            run_prog($urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) tick();
        chk("leftover_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_mizidd_alu_sequencer.md
# tt_mizidd_alu_sequencer

Program sequencer that drives the 7-bit accumulator ALU from its initiator side. It stores a short instruction list (opcode plus 7-bit operand), then on `start` issues one instruction per enabled cycle on the ALU's opcode/operand inputs. After the last instruction it captures the ALU's accumulator and carry and reports completion. It sits between the input switches/bidirectional pins and the ALU, replacing hand-toggled opcodes.

## Interface
- `DEPTH`, 8: program entries (power of two, 2..16).
- `W`, 7: operand and accumulator width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  global enable. While low, all registers hold and `alu_opcode` is forced to NOP.
- `prog_clr`  in  1  in IDLE, empties the program (count := 0).
- `prog_we`  in  1  in IDLE, appends `prog_data` at index count.
- `prog_data`  in  3+W  {opcode[2:0], operand[W-1:0]}.
- `start`  in  1  in IDLE with count > 0, begins execution.
- `alu_opcode`  out  3  opcode to ALU.
- `alu_operand`  out  W  operand to ALU.
- `alu_accu`  in  W  ALU accumulator.
- `alu_carry`  in  1  ALU carry flag.
- `busy`  out  1  high from the start edge until the done edge.
- `done`  out  1  one-cycle pulse when the result is captured.
- `result`  out  W  captured accumulator.
- `result_carry`  out  1  captured carry.
- `prog_count`  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Opcodes: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 111 HALT (local to the sequencer, never sent to the ALU). 100–110 are reserved and issued as 000 with operand 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `prog_clr` has priority over `prog_we`.
  - A write when count == DEPTH is dropped silently.
  - `start` has priority over both; a write or clear in the same cycle as an accepted `start` is dropped.
  - `start` with count == 0 is ignored.
- Accepted `start`: load entry 0 into the output registers, set rd_ptr := 1, go to RUN.
- RUN, per enabled edge:
  - If rd_ptr < count and entry[rd_ptr] is not HALT: load it and increment rd_ptr.
  - Otherwise: load NOP/0 and go to DRAIN.
- HALT at entry 0 when `start` is accepted: load NOP, go to DRAIN. `result` then equals the unchanged ALU accumulator.
- DRAIN: one cycle with NOP output, so the ALU registers the last instruction. Then go to DONE.
- DONE: `result`/`result_carry` := `alu_accu`/`alu_carry`, `done` = 1, `busy` := 0, go to IDLE.
- `start`, `prog_we` and `prog_clr` are ignored while `busy`.
- The program persists across runs; a second `start` re-executes it.
- Program memory is not reset. Entries at or beyond count are never read.
- The sequencer performs no arithmetic; carry semantics belong to the ALU.

## Timing
- Reset values: `alu_opcode` 0, `alu_operand` 0, `busy` 0, `done` 0, `result` 0, `result_carry` 0, `prog_count` 0. State IDLE, rd_ptr 0.
- `alu_opcode`/`alu_operand` are registered. The only combinational path is the NOP force from `ena`.
- With N issued instructions, start sampled at edge E0:
  - instruction i is presented after E_i;
  - NOP is presented after E_N;
  - `done` is high after E_{N+1} for exactly one enabled cycle.
  - Latency from start to done is N+1 edges; `busy` is high for N+1 cycles.
- `ena` low for k cycles stretches every subsequent event by k. The ALU only ever sees NOP while `ena` is low.
- Reset mid-run returns to IDLE immediately with no `done` pulse and count 0.

## Structure
- Shared package `tt_mizidd_alu_pkg` holds:
  - opcode constants NOP/LOAD/ADD/SUB/HALT;
  - the instruction width (3+W);
  - the state encoding.
- The ALU imports the same opcode constants.
- Sub-module `tt_mizidd_alu_prog_mem`: DEPTH×(3+W) register file with one write port and one asynchronous read port, no reset.

## Test plan
- Program LOAD 5, ADD 3, SUB 2 with an ALU model in the loop; start at E0 → `done` after E4, `result` = 6, `busy` high for 4 cycles.
- Reset, then program LOAD 127, ADD 1 → `result` = 0, `result_carry` = 1.
- Program LOAD 9, HALT, ADD 1 → only LOAD is issued, `done` after E2, `result` = 9, ADD never reaches the ALU.
- Nine `prog_we` with DEPTH = 8 → `prog_count` = 8, ninth write dropped. `prog_clr` together with `prog_we` → count 0.
- Drop `ena` for 3 cycles mid-run of the first program → `alu_opcode` = 000 during the gap, `done` arrives 3 cycles later, `result` = 6.
- Assert `rst_n` low asynchronously mid-run → all outputs 0 with no clock edge, no `done`, `prog_count` = 0.
